// File: rtl/dfifo_pkg.sv
// Shared definitions for the distributed-RAM FIFO: output-stage state encoding
// and the capacity helper used by the top level.
package dfifo_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_VALID = 1'b1
  } fwft_state_e;

  // An FWFT output stage holds one extra word on top of the RAM depth.
  function automatic int fifo_capacity(input int addr_width, input int fwft);
    return (1 << addr_width) + ((fwft != 0) ? 1 : 0);
  endfunction

endpackage

// File: rtl/dfifo_sdpram.sv
// Single-clock simple-dual-port RAM: synchronous write, combinational read,
// intended to map onto distributed (LUT) RAM.
module dfifo_sdpram #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/distributed_fifo_fwft.sv
// Synchronous FIFO over distributed RAM with registered status flags and an
// optional first-word-fall-through output stage.
module distributed_fifo_fwft
  import dfifo_pkg::*;
#(
  parameter int ADDR_WIDTH       = 4,
  parameter int DATA_WIDTH       = 32,
  parameter int FWFT             = 0,
  parameter int ALMOST_FULL_NUM  = 4,
  parameter int ALMOST_EMPTY_NUM = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_en,
  output logic                  full,
  output logic                  almost_full,
  output logic                  overflow,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  rd_en,
  output logic                  empty,
  output logic                  almost_empty,
  output logic                  underflow,
  output logic [ADDR_WIDTH:0]   water_level
);

  localparam int CAPACITY = fifo_capacity(ADDR_WIDTH, FWFT);
  localparam int LVL_W    = ADDR_WIDTH + 1;

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]      level_q, level_d, ram_cnt_q, ram_cnt_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d, ram_rd_data;
  fwft_state_e           state_q, state_d;
  logic full_q, full_d, almost_full_q, almost_full_d;
  logic empty_q, empty_d, almost_empty_q, almost_empty_d;
  logic overflow_q, overflow_d, underflow_q, underflow_d;
  logic wr_acc, rd_acc, load, ram_ne;

  dfifo_sdpram #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_ram (
    .clk    (clk),
    .wr_en  (wr_acc),
    .wr_addr(wr_ptr_q),
    .wr_data(wr_data),
    .rd_addr(rd_ptr_q),
    .rd_data(ram_rd_data)
  );

  always_comb begin
    wr_acc = wr_en & ~full_q;
    rd_acc = rd_en & ~empty_q;
    ram_ne = (ram_cnt_q != '0);

    // load moves the RAM head into rd_data; in FWFT mode it also refills an
    // idle output stage without any read request.
    if (FWFT != 0) begin
      load = ram_ne && ((state_q == ST_IDLE) || rd_acc);
    end else begin
      load = rd_acc;
    end

    state_d = state_q;
    if (FWFT != 0) begin
      if (load) begin
        state_d = ST_VALID;
      end else if (rd_acc) begin
        state_d = ST_IDLE;
      end
    end

    wr_ptr_d  = wr_acc ? wr_ptr_q + ADDR_WIDTH'(1) : wr_ptr_q;
    rd_ptr_d  = load ? rd_ptr_q + ADDR_WIDTH'(1) : rd_ptr_q;
    rd_data_d = load ? ram_rd_data : rd_data_q;
    ram_cnt_d = ram_cnt_q + LVL_W'(wr_acc) - LVL_W'(load);
    level_d   = level_q + LVL_W'(wr_acc) - LVL_W'(rd_acc);

    full_d         = (int'(level_d) == CAPACITY);
    almost_full_d  = (int'(level_d) >= CAPACITY - ALMOST_FULL_NUM);
    almost_empty_d = (int'(level_d) <= ALMOST_EMPTY_NUM);
    empty_d        = (FWFT != 0) ? (state_d == ST_IDLE) : (level_d == '0);
    overflow_d     = wr_en & full_q;
    underflow_d    = rd_en & empty_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      level_q        <= '0;
      ram_cnt_q      <= '0;
      rd_data_q      <= '0;
      state_q        <= ST_IDLE;
      full_q         <= 1'b0;
      almost_full_q  <= 1'b0;
      empty_q        <= 1'b1;
      almost_empty_q <= 1'b1;
      overflow_q     <= 1'b0;
      underflow_q    <= 1'b0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      level_q        <= level_d;
      ram_cnt_q      <= ram_cnt_d;
      rd_data_q      <= rd_data_d;
      state_q        <= state_d;
      full_q         <= full_d;
      almost_full_q  <= almost_full_d;
      empty_q        <= empty_d;
      almost_empty_q <= almost_empty_d;
      overflow_q     <= overflow_d;
      underflow_q    <= underflow_d;
    end
  end

  assign full         = full_q;
  assign almost_full  = almost_full_q;
  assign overflow     = overflow_q;
  assign rd_data      = rd_data_q;
  assign empty        = empty_q;
  assign almost_empty = almost_empty_q;
  assign underflow    = underflow_q;
  assign water_level  = level_q;

endmodule

// File: tb/tb_distributed_fifo_fwft.sv
// Directed bench: a standard-mode and an FWFT-mode FIFO (depth 16, 8-bit data)
// checked against hand-computed vectors and short corner-case sequences.
module tb_distributed_fifo_fwft;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       s_wr_en = 1'b0, s_rd_en = 1'b0;
  logic [7:0] s_wr_data = 8'h00, s_rd_data;
  logic       s_full, s_af, s_ovf, s_empty, s_ae, s_udf;
  logic [4:0] s_level;

  logic       f_wr_en = 1'b0, f_rd_en = 1'b0;
  logic [7:0] f_wr_data = 8'h00, f_rd_data;
  logic       f_full, f_af, f_ovf, f_empty, f_ae, f_udf;
  logic [4:0] f_level;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       wr_en;
    logic       rd_en;
    logic [7:0] wr_data;
    logic [4:0] lvl;
    logic       empty;
    logic       full;
    logic       af;
    logic       ae;
    logic       chk_rd;
    logic [7:0] rd_data;
  } vec_t;

  vec_t vecs [32];

  always #5 clk = ~clk;

  distributed_fifo_fwft #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .FWFT(0)) dut_std (
    .clk(clk), .rst(rst), .wr_data(s_wr_data), .wr_en(s_wr_en), .full(s_full),
    .almost_full(s_af), .overflow(s_ovf), .rd_data(s_rd_data), .rd_en(s_rd_en),
    .empty(s_empty), .almost_empty(s_ae), .underflow(s_udf), .water_level(s_level)
  );

  distributed_fifo_fwft #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .FWFT(1)) dut_fw (
    .clk(clk), .rst(rst), .wr_data(f_wr_data), .wr_en(f_wr_en), .full(f_full),
    .almost_full(f_af), .overflow(f_ovf), .rd_data(f_rd_data), .rd_en(f_rd_en),
    .empty(f_empty), .almost_empty(f_ae), .underflow(f_udf), .water_level(f_level)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic cyc_s(input logic we, input logic re, input logic [7:0] d);
    s_wr_en = we; s_rd_en = re; s_wr_data = d;
    @(posedge clk); #1;
    s_wr_en = 1'b0; s_rd_en = 1'b0;
  endtask

  task automatic cyc_f(input logic we, input logic re, input logic [7:0] d);
    f_wr_en = we; f_rd_en = re; f_wr_data = d;
    @(posedge clk); #1;
    f_wr_en = 1'b0; f_rd_en = 1'b0;
  endtask

  initial begin
    // Fill/drain table: 16 writes of 0x00..0x0F then 16 reads.
    for (int i = 0; i < 16; i++) begin
      vecs[i].wr_en   = 1'b1;
      vecs[i].rd_en   = 1'b0;
      vecs[i].wr_data = 8'(i);
      vecs[i].lvl     = 5'(i + 1);
      vecs[i].empty   = 1'b0;
      vecs[i].full    = (i == 15);
      vecs[i].af      = (i + 1 >= 12);
      vecs[i].ae      = (i + 1 <= 4);
      vecs[i].chk_rd  = 1'b0;
      vecs[i].rd_data = 8'h00;
    end
    for (int j = 0; j < 16; j++) begin
      vecs[16+j].wr_en   = 1'b0;
      vecs[16+j].rd_en   = 1'b1;
      vecs[16+j].wr_data = 8'h00;
      vecs[16+j].lvl     = 5'(15 - j);
      vecs[16+j].empty   = (j == 15);
      vecs[16+j].full    = 1'b0;
      vecs[16+j].af      = (15 - j >= 12);
      vecs[16+j].ae      = (15 - j <= 4);
      vecs[16+j].chk_rd  = 1'b1;
      vecs[16+j].rd_data = 8'(j);
    end

    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_level", s_level, 0);
    chk("rst_empty", s_empty, 1);
    chk("rst_ae", s_ae, 1);
    chk("rst_full", s_full, 0);
    chk("rst_af", s_af, 0);
    chk("rst_ovf", s_ovf, 0);
    chk("rst_udf", s_udf, 0);
    chk("rst_rd_data", s_rd_data, 0);
    chk("rst_f_empty", f_empty, 1);
    chk("rst_f_level", f_level, 0);
    rst = 1'b0;

    for (int i = 0; i < 32; i++) begin
      cyc_s(vecs[i].wr_en, vecs[i].rd_en, vecs[i].wr_data);
      chk($sformatf("tbl%0d_level", i), s_level, vecs[i].lvl);
      chk($sformatf("tbl%0d_empty", i), s_empty, vecs[i].empty);
      chk($sformatf("tbl%0d_full", i), s_full, vecs[i].full);
      chk($sformatf("tbl%0d_af", i), s_af, vecs[i].af);
      chk($sformatf("tbl%0d_ae", i), s_ae, vecs[i].ae);
      chk($sformatf("tbl%0d_ovf", i), s_ovf, 0);
      chk($sformatf("tbl%0d_udf", i), s_udf, 0);
      if (vecs[i].chk_rd) chk($sformatf("tbl%0d_rd_data", i), s_rd_data, vecs[i].rd_data);
    end

    // Read at empty is rejected.
    cyc_s(1'b0, 1'b1, 8'h00);
    chk("empty_rd_udf", s_udf, 1);
    chk("empty_rd_level", s_level, 0);
    cyc_s(1'b0, 1'b0, 8'h00);
    chk("udf_pulse_end", s_udf, 0);

    // At full, simultaneous read/write: read accepted, write rejected.
    for (int i = 0; i < 16; i++) cyc_s(1'b1, 1'b0, 8'(8'h10 + i));
    chk("full_before", s_full, 1);
    cyc_s(1'b1, 1'b1, 8'hEE);
    chk("full_rw_ovf", s_ovf, 1);
    chk("full_rw_level", s_level, 15);
    chk("full_rw_rd_data", s_rd_data, 8'h10);
    chk("full_rw_full", s_full, 0);
    for (int j = 1; j < 16; j++) begin
      cyc_s(1'b0, 1'b1, 8'h00);
      chk($sformatf("full_drain%0d", j), s_rd_data, 8'(8'h10 + j));
    end
    chk("full_drain_empty", s_empty, 1);

    // Steady simultaneous traffic with 5 entries held.
    for (int i = 0; i < 5; i++) cyc_s(1'b1, 1'b0, 8'(8'h40 + i));
    for (int k = 0; k < 30; k++) begin
      cyc_s(1'b1, 1'b1, 8'(8'h45 + k));
      chk($sformatf("rw%0d_level", k), s_level, 5);
      chk($sformatf("rw%0d_data", k), s_rd_data, 8'(8'h40 + k));
    end
    for (int k = 0; k < 5; k++) begin
      cyc_s(1'b0, 1'b1, 8'h00);
      chk($sformatf("rw_drain%0d", k), s_rd_data, 8'(8'h5E + k));
    end
    chk("rw_drain_empty", s_empty, 1);

    // Reset with 9 entries stored, write requested in the same cycle.
    for (int i = 0; i < 9; i++) cyc_s(1'b1, 1'b0, 8'(8'h80 + i));
    chk("pre_rst_level", s_level, 9);
    rst = 1'b1;
    cyc_s(1'b1, 1'b0, 8'h99);
    rst = 1'b0;
    chk("mid_rst_level", s_level, 0);
    chk("mid_rst_empty", s_empty, 1);
    cyc_s(1'b1, 1'b0, 8'h3C);
    chk("post_rst_wr_level", s_level, 1);
    cyc_s(1'b0, 1'b1, 8'h00);
    chk("post_rst_rd_data", s_rd_data, 8'h3C);
    chk("post_rst_empty", s_empty, 1);

    // FWFT: single word falls through to the output.
    cyc_f(1'b1, 1'b0, 8'hA5);
    chk("fw_wr_level", f_level, 1);
    cyc_f(1'b0, 1'b0, 8'h00);
    chk("fw_lat_empty", f_empty, 0);
    chk("fw_lat_rd_data", f_rd_data, 8'hA5);
    cyc_f(1'b0, 1'b1, 8'h00);
    chk("fw_rd_empty", f_empty, 1);
    chk("fw_rd_level", f_level, 0);
    chk("fw_rd_udf", f_udf, 0);

    // FWFT capacity is 17; further writes overflow.
    for (int i = 0; i < 20; i++) begin
      cyc_f(1'b1, 1'b0, 8'(8'h60 + i));
      chk($sformatf("fw_fill%0d_level", i), f_level, (i + 1 > 17) ? 17 : i + 1);
      chk($sformatf("fw_fill%0d_full", i), f_full, (i >= 16));
      chk($sformatf("fw_fill%0d_ovf", i), f_ovf, (i >= 17));
      chk($sformatf("fw_fill%0d_af", i), f_af, (i + 1 >= 13));
    end
    cyc_f(1'b0, 1'b0, 8'h00);
    chk("fw_ovf_end", f_ovf, 0);
    for (int j = 0; j < 17; j++) begin
      chk($sformatf("fw_head%0d", j), f_rd_data, 8'(8'h60 + j));
      chk($sformatf("fw_head%0d_empty", j), f_empty, 0);
      cyc_f(1'b0, 1'b1, 8'h00);
      chk($sformatf("fw_rd%0d_level", j), f_level, 16 - j);
    end
    chk("fw_drain_empty", f_empty, 1);
    cyc_f(1'b0, 1'b1, 8'h00);
    chk("fw_empty_udf", f_udf, 1);
    chk("fw_empty_level", f_level, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
